irq_ctrl_mc: RTL

//  Multi-channel interrupt controller; parametrised successor of the single-line debounced IRQ pulser.
//  Per channel: 2-FF synchroniser, debounce, and a configurable trigger mode (rise/fall/both/level-high).

---
 rtl/irq_ctrl_pkg.sv | 14 +
 rtl/irq_debounce_ch.sv | 42 ++++
 rtl/irq_ctrl_mc.sv | 79 +++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the multi-channel interrupt controller.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_MODE_RISE  = 2'b00;
    localparam logic [1:0] IRQ_MODE_FALL  = 2'b01;
    localparam logic [1:0] IRQ_MODE_BOTH  = 2'b10;
    localparam logic [1:0] IRQ_MODE_LEVEL = 2'b11;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_debounce_ch.sv
// One IRQ channel front end: 2-FF synchroniser, mismatch-count debounce and a
// one-cycle delayed copy of the debounced level for edge detection.
module irq_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic stable,
    output logic stable_d1
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stable    <= 1'b0;
            stable_d1 <= 1'b0;
            cnt       <= '0;
        end else begin
            sync1     <= in;
            sync2     <= sync1;
            stable_d1 <= stable;
            // The counter clears at terminal count, so it can never wrap.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_mc.sv
// Multi-channel interrupt controller: per-channel trigger decode, sticky W1C
// pending bits, aggregated level IRQ, new-pending pulse and lowest-index ID.
module irq_ctrl_mc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS,
    localparam int IDW            = id_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ext_irq_in,
    input  logic [NUM_CH-1:0]   cfg_enable,
    input  logic [2*NUM_CH-1:0] cfg_mode,
    input  logic [NUM_CH-1:0]   pend_clr,
    output logic [NUM_CH-1:0]   pending,
    output logic                irq_out,
    output logic                irq_pulse_out,
    output logic [IDW-1:0]      irq_id
);

    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] stable_d1;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] set_bits;
    logic [NUM_CH-1:0] pend_next;
    logic [NUM_CH-1:0] masked;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (ext_irq_in[i]),
            .stable    (stable[i]),
            .stable_d1 (stable_d1[i])
        );
    end

    // stable_d1 tracks stable regardless of mode, so a mode change alone is not an edge.
    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (cfg_mode[2*i +: 2])
                IRQ_MODE_RISE: evt[i] = stable[i] & ~stable_d1[i];
                IRQ_MODE_FALL: evt[i] = ~stable[i] & stable_d1[i];
                IRQ_MODE_BOTH: evt[i] = stable[i] ^ stable_d1[i];
                default:       evt[i] = stable[i];
            endcase
        end
    end

    assign set_bits  = evt & cfg_enable;
    assign pend_next = (pending & ~pend_clr) | set_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending       <= '0;
            irq_pulse_out <= 1'b0;
        end else begin
            pending       <= pend_next;
            irq_pulse_out <= |(pend_next & ~pending);
        end
    end

    assign masked  = pending & cfg_enable;
    assign irq_out = |masked;

    always_comb begin
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (masked[i]) irq_id = IDW'(i);
        end
    end

endmodule
